// File: rtl/pong_scr_pkg.sv
// Shared screen geometry and writer state encoding.
// Used by the frame-buffer writer and the VGA readout path.
package pong_scr_pkg;

  localparam int SCR_WIDTH  = 160;
  localparam int SCR_HEIGHT = 120;
  localparam int SCR_PIXELS = SCR_WIDTH * SCR_HEIGHT;
  localparam int SCR_ADDR_W = 15;
  localparam int COLOUR_W   = 3;
  localparam int XY_W       = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } scr_state_t;

endpackage

// File: rtl/scr_addr_calc.sv
// Pixel range check and linear frame-buffer address (y*WIDTH+x).
// Purely combinational; shared by readers and writers.
module scr_addr_calc
  import pong_scr_pkg::*;
#(
  parameter int WIDTH  = SCR_WIDTH,
  parameter int HEIGHT = SCR_HEIGHT,
  parameter int ADDR_W = SCR_ADDR_W
) (
  input  logic [XY_W-1:0]   x,
  input  logic [XY_W-1:0]   y,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);

  assign in_range = (x < XY_W'(WIDTH))
                 && (y < XY_W'(HEIGHT));

  assign addr = ADDR_W'(y) * ADDR_W'(WIDTH)
              + ADDR_W'(x);

endmodule

// File: rtl/scr_writer.sv
// Frame-buffer write port driver: pixel plots plus full-screen fill.
// Define SCR_WRITER_BBOX_EN to add the dirty bounding-box outputs.
module scr_writer
  import pong_scr_pkg::*;
#(
  parameter int WIDTH    = SCR_WIDTH,
  parameter int HEIGHT   = SCR_HEIGHT,
  parameter int ADDR_W   = SCR_ADDR_W,
  parameter int COLOUR_W = pong_scr_pkg::COLOUR_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot,
  input  logic [XY_W-1:0]     x,
  input  logic [XY_W-1:0]     y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                ready,
  output logic                busy,
  output logic                clear_done,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_wren,
`ifdef SCR_WRITER_BBOX_EN
  output logic                dirty_valid,
  output logic [XY_W-1:0]     dirty_xmin,
  output logic [XY_W-1:0]     dirty_xmax,
  output logic [XY_W-1:0]     dirty_ymin,
  output logic [XY_W-1:0]     dirty_ymax,
`endif
  output logic [7:0]          drop_count
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(WIDTH * HEIGHT - 1);

  scr_state_t state_q, state_d;

  logic              in_range;
  logic [ADDR_W-1:0] calc_addr;
  logic              accept;
  logic              reject;
  logic              start;
  logic              last;

  scr_addr_calc #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .x        (x),
    .y        (y),
    .in_range (in_range),
    .addr     (calc_addr)
  );

  assign ready  = (state_q == IDLE) && !clear_req;
  assign busy   = (state_q == CLEAR);
  assign start  = (state_q == IDLE) && clear_req;
  assign last   = busy && (mem_addr == LAST);
  assign accept = plot && ready && in_range;
  assign reject = plot && !accept;

  assign clear_done = last;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clear_req) state_d = CLEAR;
      CLEAR: if (last)      state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // The fill walks mem_addr itself; mem_data holds the latched colour.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      drop_count <= '0;
    end else begin
      mem_wren <= 1'b0;
      if (start) begin
        mem_wren <= 1'b1;
        mem_addr <= '0;
        mem_data <= clear_colour;
      end else if (busy && !last) begin
        mem_wren <= 1'b1;
        mem_addr <= mem_addr + 1'b1;
      end else if (accept) begin
        mem_wren <= 1'b1;
        mem_addr <= calc_addr;
        mem_data <= colour;
      end
      if (reject && drop_count != 8'hff)
        drop_count <= drop_count + 8'd1;
    end
  end

`ifdef SCR_WRITER_BBOX_EN
  always_ff @(posedge clk) begin
    if (!resetn || last) begin
      dirty_valid <= 1'b0;
      dirty_xmin  <= '0;
      dirty_xmax  <= '0;
      dirty_ymin  <= '0;
      dirty_ymax  <= '0;
    end else if (accept) begin
      dirty_valid <= 1'b1;
      if (!dirty_valid || x < dirty_xmin)
        dirty_xmin <= x;
      if (!dirty_valid || x > dirty_xmax)
        dirty_xmax <= x;
      if (!dirty_valid || y < dirty_ymin)
        dirty_ymin <= y;
      if (!dirty_valid || y > dirty_ymax)
        dirty_ymax <= y;
    end
  end
`endif

endmodule

// File: tb/tb_scr_writer.sv
// Directed scoreboard bench for scr_writer.
// Build with SCR_WRITER_BBOX_EN to exercise the bounding box.
module tb_scr_writer;
  import pong_scr_pkg::*;

  logic                clk = 1'b0;
  logic                resetn;
  logic                plot;
  logic [XY_W-1:0]     x;
  logic [XY_W-1:0]     y;
  logic [COLOUR_W-1:0] colour;
  logic                clear_req;
  logic [COLOUR_W-1:0] clear_colour;
  logic                ready;
  logic                busy;
  logic                clear_done;
  logic [SCR_ADDR_W-1:0] mem_addr;
  logic [COLOUR_W-1:0] mem_data;
  logic                mem_wren;
  logic [7:0]          drop_count;
`ifdef SCR_WRITER_BBOX_EN
  logic                dirty_valid;
  logic [XY_W-1:0]     dirty_xmin;
  logic [XY_W-1:0]     dirty_xmax;
  logic [XY_W-1:0]     dirty_ymin;
  logic [XY_W-1:0]     dirty_ymax;
`endif

  always #5 clk = ~clk;

  scr_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .ready        (ready),
    .busy         (busy),
    .clear_done   (clear_done),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
`ifdef SCR_WRITER_BBOX_EN
    .dirty_valid  (dirty_valid),
    .dirty_xmin   (dirty_xmin),
    .dirty_xmax   (dirty_xmax),
    .dirty_ymin   (dirty_ymin),
    .dirty_ymax   (dirty_ymax),
`endif
    .drop_count   (drop_count)
  );

  typedef struct {
    int addr;
    int data;
    bit done;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_drop = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = i;
      e.data = c;
      e.done = (i == SCR_PIXELS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drop_one();
    if (exp_drop < 255) exp_drop++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < SCR_PIXELS + 100) begin
      tick();
      n++;
    end
    chk("clear_timeout", busy, 0);
  endtask

  // Every write the DUT makes must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL spurious_write: observed addr %0d expected none",
               mem_addr);
      end
      if (sb.size() > 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_data, e.data);
        chk("wr_done", clear_done, e.done);
      end
    end else if (resetn === 1'b1) begin
      chk("done_without_write", clear_done, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int px[4] = '{0, 159, 159, 0};
  int py[4] = '{0, 119, 0, 119};
  int pc[4] = '{1, 7, 2, 4};

  initial begin
    int n;
    wr_t e;
    resetn       = 1'b0;
    plot         = 1'b0;
    x            = '0;
    y            = '0;
    colour       = '0;
    clear_req    = 1'b0;
    clear_colour = '0;
    repeat (3) tick();
    chk("rst_ready", ready, 1);
    chk("rst_wren", mem_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    resetn = 1'b1;
    tick();

    x = 10'd5; y = 10'd2; colour = 3'b101; plot = 1'b1;
    e.addr = 325; e.data = 5; e.done = 0;
    sb.push_back(e);
    tick();
    plot = 1'b0;
    chk("plot_wren", mem_wren, 1);
    chk("plot_addr", mem_addr, 325);
    tick();
    chk("plot_one_cycle", mem_wren, 0);
    chk("plot_hold_addr", mem_addr, 325);
    chk("plot_hold_data", mem_data, 5);

    for (int i = 0; i < 4; i++) begin
      x = px[i][9:0]; y = py[i][9:0];
      colour = pc[i][2:0]; plot = 1'b1;
      e.addr = py[i] * 160 + px[i];
      e.data = pc[i]; e.done = 0;
      sb.push_back(e);
      tick();
      chk("b2b_wren", mem_wren, 1);
    end
    plot = 1'b0;
    tick();
    chk("b2b_drained", sb.size(), 0);

    x = 10'd160; y = 10'd0; plot = 1'b1; drop_one();
    tick();
    x = 10'd0; y = 10'd120; drop_one();
    tick();
    plot = 1'b0;
    tick();
    chk("oor_drop", drop_count, exp_drop);
    chk("oor_nowrite", mem_wren, 0);

    clear_colour = 3'b001; clear_req = 1'b1;
    #1;
    chk("ready_clrreq", ready, 0);
    push_clear(1, SCR_PIXELS);
    tick();
    clear_req = 1'b0;
    clear_colour = 3'b111;
    chk("clr_busy", busy, 1);
    chk("clr_ready", ready, 0);
    chk("clr_first", mem_addr, 0);
    repeat (100) tick();
    x = 10'd3; y = 10'd3; plot = 1'b1; drop_one();
    tick();
    plot = 1'b0;
    chk("clr_plot_drop", drop_count, exp_drop);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_idle();
    chk("clr_ready_after", ready, 1);
    chk("clr_drained", sb.size(), 0);
    chk("clr_nowrite_after", mem_wren, 0);

    plot = 1'b1; x = 10'd200; y = 10'd0;
    for (int i = 0; i < 260; i++) begin
      drop_one();
      tick();
    end
    plot = 1'b0;
    tick();
    chk("drop_saturate", drop_count, 255);

    exp_drop = 0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("drop_reset", drop_count, 0);

    x = 10'd7; y = 10'd7; colour = 3'b011; plot = 1'b1;
    clear_req = 1'b1; clear_colour = 3'b110;
    drop_one();
    push_clear(6, 5001);
    tick();
    plot = 1'b0; clear_req = 1'b0;
    chk("pc_drop", drop_count, exp_drop);
    chk("pc_addr0", mem_addr, 0);
    chk("pc_wren", mem_wren, 1);
    n = 0;
    while (!(mem_wren === 1'b1 && mem_addr == 15'd5000)
           && n < 6000) begin
      tick();
      n++;
    end
    chk("reach_5000", mem_addr, 5000);
    resetn = 1'b0;
    tick();
    chk("abort_wren", mem_wren, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", clear_done, 0);
    chk("abort_ready", ready, 1);
    resetn = 1'b1;
    repeat (3) tick();
    chk("abort_quiet", mem_wren, 0);
    chk("abort_drained", sb.size(), 0);

`ifdef SCR_WRITER_BBOX_EN
    chk("bb_rst_valid", dirty_valid, 0);
    x = 10'd10; y = 10'd20; colour = 3'b001; plot = 1'b1;
    e.addr = 3210; e.data = 1; e.done = 0;
    sb.push_back(e);
    tick();
    chk("bb_first_valid", dirty_valid, 1);
    chk("bb_first_xmin", dirty_xmin, 10);
    chk("bb_first_ymax", dirty_ymax, 20);
    x = 10'd3; y = 10'd50; colour = 3'b010;
    e.addr = 8003; e.data = 2;
    sb.push_back(e);
    tick();
    x = 10'd40; y = 10'd7; colour = 3'b011;
    e.addr = 1160; e.data = 3;
    sb.push_back(e);
    tick();
    plot = 1'b0;
    chk("bb_valid", dirty_valid, 1);
    chk("bb_xmin", dirty_xmin, 3);
    chk("bb_xmax", dirty_xmax, 40);
    chk("bb_ymin", dirty_ymin, 7);
    chk("bb_ymax", dirty_ymax, 50);
    clear_colour = 3'b000; clear_req = 1'b1;
    push_clear(0, SCR_PIXELS);
    tick();
    clear_req = 1'b0;
    wait_idle();
    chk("bb_clr_valid", dirty_valid, 0);
    chk("bb_clr_xmax", dirty_xmax, 0);
    chk("bb_clr_ymax", dirty_ymax, 0);
`endif

    tick();
    chk("final_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
